// File: rtl/bios_pkg.sv
// rtl/bios_pkg.sv - BIOS opcode and state encodings shared by the request unit
package bios_pkg;

  localparam logic [7:0] OP_HALT       = 8'h01;
  localparam logic [7:0] OP_GETTIME    = 8'hB0;
  localparam logic [7:0] OP_LOCK       = 8'hB1;
  localparam logic [7:0] OP_RELEASE    = 8'hB2;
  localparam logic [7:0] OP_GETQUANTUM = 8'hB3;
  localparam logic [7:0] OP_SETQUANTUM = 8'hB4;
  localparam logic [7:0] OP_BIOSINT    = 8'hB5;

  typedef enum logic [1:0] {
    BS_INV         = 2'd0,
    BS_BIOSEXEC    = 2'd1,
    BS_PROCESSEXEC = 2'd2,
    BS_PROCESSINT  = 2'd3
  } bios_state_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESP    = 2'd2,
    ST_HANDOFF = 2'd3
  } fsm_state_e;

  function automatic logic is_bios_op(input logic [7:0] op);
    case (op)
      OP_HALT, OP_GETTIME, OP_LOCK, OP_RELEASE,
      OP_GETQUANTUM, OP_SETQUANTUM, OP_BIOSINT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bios_preempt_detect.sv
// rtl/bios_preempt_detect.sv - PROCESSEXEC->PROCESSINT edge detector
// The pulse is held pending until the request FSM is about to be idle.
module bios_preempt_detect
  import bios_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] bios_state,
  input  logic       idle_next,
  output logic       preempt_req
);

  logic [1:0] prev_state;
  logic       pending;
  logic       fire;

  assign fire = pending ||
                (prev_state == BS_PROCESSEXEC && bios_state == BS_PROCESSINT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_state  <= BS_INV;
      pending     <= 1'b0;
      preempt_req <= 1'b0;
    end else begin
      prev_state  <= bios_state;
      preempt_req <= fire && idle_next;
      pending     <= fire && !idle_next;
    end
  end

endmodule

// File: rtl/bios_request_unit.sv
// rtl/bios_request_unit.sv - issues BIOS-class instructions and stalls the pipe
// while a BIOS request or handoff is in flight.
module bios_request_unit
  import bios_pkg::*;
#(
  parameter int HANDOFF_TIMEOUT = 1024,
  parameter int OPW             = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  input  logic [OPW-1:0] instr_opcode,
  input  logic [31:0]    instr_rs_data,
  input  logic [4:0]     instr_rd,
  input  logic           inst_retire,
  input  logic [31:0]    bios_info,
  input  logic [1:0]     bios_state,
  output logic [OPW-1:0] op_out,
  output logic [31:0]    info_out,
  output logic           stall,
  output logic           wb_en,
  output logic [4:0]     wb_addr,
  output logic [31:0]    wb_data,
  output logic           done_inst,
  output logic           preempt_req,
  output logic           err
);

  localparam int CW = $clog2(HANDOFF_TIMEOUT);

  fsm_state_e     state;
  logic [OPW-1:0] op_q;
  logic [4:0]     rd_q;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           is_get;
  logic           timeout_hit;
  logic           idle_next;

  assign accept      = instr_valid && is_bios_op(instr_opcode);
  assign is_get      = (op_q == OP_GETTIME) || (op_q == OP_GETQUANTUM);
  assign timeout_hit = (cnt == CW'(HANDOFF_TIMEOUT - 1));

  // Lets the preempt detector release its pulse on the first IDLE cycle.
  always_comb begin
    idle_next = 1'b0;
    case (state)
      ST_IDLE:    idle_next = !accept;
      ST_ISSUE:   idle_next = !is_get && (op_q != OP_BIOSINT);
      ST_RESP:    idle_next = 1'b1;
      ST_HANDOFF: idle_next = (bios_state == BS_PROCESSEXEC) || timeout_hit;
      default:    idle_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      cnt       <= '0;
      op_out    <= '0;
      info_out  <= '0;
      stall     <= 1'b0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      done_inst <= 1'b0;
      err       <= 1'b0;
    end else begin
      op_out <= '0;
      wb_en  <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          done_inst <= inst_retire;
          if (accept) begin
            state     <= ST_ISSUE;
            op_out    <= instr_opcode;
            op_q      <= instr_opcode;
            rd_q      <= instr_rd;
            stall     <= 1'b1;
            done_inst <= 1'b0;
            info_out  <= (instr_opcode == OP_SETQUANTUM) ? instr_rs_data : '0;
          end
        end
        ST_ISSUE: begin
          info_out <= '0;
          if (is_get) begin
            state   <= ST_RESP;
            wb_en   <= 1'b1;
            wb_addr <= rd_q;
            wb_data <= bios_info;
          end else if (op_q == OP_BIOSINT) begin
            state     <= ST_HANDOFF;
            done_inst <= 1'b1;
            cnt       <= '0;
          end else begin
            state     <= ST_IDLE;
            stall     <= 1'b0;
            done_inst <= inst_retire;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          stall     <= 1'b0;
          done_inst <= inst_retire;
        end
        ST_HANDOFF: begin
          if (bios_state == BS_PROCESSEXEC || timeout_hit) begin
            err       <= (bios_state != BS_PROCESSEXEC);
            state     <= ST_IDLE;
            stall     <= 1'b0;
            cnt       <= '0;
            done_inst <= inst_retire;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bios_preempt_detect u_preempt (
    .clk         (clk),
    .rst_n       (rst_n),
    .bios_state  (bios_state),
    .idle_next   (idle_next),
    .preempt_req (preempt_req)
  );

endmodule

// File: doc/bios_request_unit.md
Name: bios_request_unit

Overview:
- Processor-side counterpart of the BIOS supervisor; sits between the processor decode/writeback stages and the BIOS control inputs.
- Turns BIOS-class instructions (LOCK, RELEASE, BIOSINT, SETQUANTUM, GETTIME, GETQUANTUM, HALT) into one-cycle opcode/info strobes, captures bios_info replies into the register file and stalls the pipeline while a request is in flight.
- Tracks BIOS state to flag preemption and to drive done_inst, so BIOS state changes only happen on instruction boundaries.

Parameters:
- HANDOFF_TIMEOUT, 1024, max cycles to wait for BIOS to reach PROCESSEXEC after BIOSINT; on expiry the unit raises err.
- OPW, 8, opcode width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  decode stage presents an instruction this cycle.
- instr_opcode  in  8  opcode bits [0:7] of the instruction.
- instr_rs_data  in  32  rs operand value; used by SETQUANTUM.
- instr_rd  in  5  destination register for GETTIME/GETQUANTUM.
- inst_retire  in  1  processor completed the current instruction.
- bios_info  in  32  BIOS reply data.
- bios_state  in  2  BIOS state (0 INV, 1 BIOSEXEC, 2 PROCESSEXEC, 3 PROCESSINT).
- op_out  out  8  drives the BIOS processor_opcode_operation input.
- info_out  out  32  drives the BIOS processor_info input.
- stall  out  1  freezes the processor pipeline.
- wb_en  out  1  one-cycle register-file write strobe.
- wb_addr  out  5  write address.
- wb_data  out  32  write data.
- done_inst  out  1  instruction boundary indication to BIOS.
- preempt_req  out  1  one-cycle pulse on PROCESSEXEC→PROCESSINT.
- err  out  1  one-cycle pulse on handoff timeout.

Behaviour:
- Reset values: op_out=8'h00, info_out=0, stall=0, wb_en=0, wb_addr=0, wb_data=0, done_inst=0, preempt_req=0, err=0, FSM=IDLE, timeout counter=0.
- BIOS opcodes (shared package): GETTIME B0, LOCK B1, RELEASE B2, GETQUANTUM B3, SETQUANTUM B4, BIOSINT B5, HALT 01.
- op_out is 00 in every cycle except ISSUE.
- FSM states:
  - IDLE: if instr_valid and the opcode is in the BIOS set → ISSUE. Latch opcode and rd; latch instr_rs_data into info_out for SETQUANTUM. stall=1 from the next cycle. Non-BIOS opcodes are ignored.
  - ISSUE (1 cycle): op_out=latched opcode.
    - GETTIME or GETQUANTUM → RESP.
    - BIOSINT → HANDOFF.
    - Any other → IDLE; stall drops.
  - RESP (1 cycle): BIOS has registered bios_info at the ISSUE posedge. Set wb_data=bios_info, wb_addr=rd, wb_en=1 for exactly this cycle, then → IDLE.
  - HANDOFF: stall=1; done_inst=1. Count cycles.
    - bios_state==PROCESSEXEC → IDLE; counter clears.
    - Counter reaches HANDOFF_TIMEOUT-1 → err pulse, → IDLE.
- GETTIME/GETQUANTUM latency: ISSUE at cycle N+1, wb_en at cycle N+2, stall high for cycles N+1..N+2.
- done_inst outside HANDOFF is registered inst_retire, i.e. it is high the cycle after a retire, while no request is in flight.
- Preemption:
  - Track the previous bios_state. On 2→3, preempt_req pulses for one cycle.
  - If a request is in ISSUE or RESP at that moment, it completes first; preempt_req is delayed until the FSM returns to IDLE.
- HALT is issued like LOCK; the unit then stays in IDLE and does not hold stall.
- Back-to-back BIOS instructions: a new instr_valid is accepted only in IDLE. stall guarantees decode holds the instruction; no queueing.
- instr_valid while bios_state==INV: still issued; BIOS ignores it, no special handling.
- Asynchronous reset mid-request: all outputs return to reset values immediately, the FSM returns to IDLE and any in-flight wb_en is dropped.

Decomposition:
- Package bios_pkg:
  - BIOS opcode constants.
  - bios_state encodings (INV, BIOSEXEC, PROCESSEXEC, PROCESSINT).
  - Local FSM state encoding.
  - Helper function is_bios_op(opcode).
- Sub-module bios_preempt_detect: bios_state edge detector producing the deferred preempt_req pulse.

Test Plan:
- Reset then GETTIME with bios_info=32'd1234, rd=5 → op_out=B0 for one cycle; next cycle wb_en=1, wb_addr=5, wb_data=1234; stall high exactly 2 cycles.
- SETQUANTUM with rs_data=32'd500 → op_out=B4 and info_out=500 for one cycle; no wb_en; stall high 1 cycle.
- BIOSINT with bios_state moving 1→2 after 3 cycles → done_inst high throughout HANDOFF; unit returns to IDLE on the cycle after bios_state=2; err stays 0.
- BIOSINT with bios_state held at 1, HANDOFF_TIMEOUT=16 → err pulses once, 16 cycles after entering HANDOFF; unit returns to IDLE.
- bios_state 2→3 while GETQUANTUM is in ISSUE → wb_en completes first; preempt_req pulses exactly one cycle later, on the first IDLE cycle.
- rst_n low during RESP → wb_en drops immediately with no write; after release, a LOCK issues op_out=B1 normally.
